// File: rtl/twiddle_fetch.sv
// Twiddle-factor fetch sequencer: issues stage-strided ROM reads under credit control
// and streams the returned words through a FWFT FIFO. Optional TW_CONJ_EN conjugates on read.
`ifndef DATA_WIDTH
`define DATA_WIDTH 16
`endif

module twiddle_fetch #(
    parameter int DATA_WIDTH = `DATA_WIDTH,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    start,
    input  logic [2:0]              stage,
    output logic                    busy,
    output logic                    done,
    output logic                    rom_en,
    output logic [3:0]              rom_addr,
    input  logic [2*DATA_WIDTH-1:0] rom_data,
    output logic [2*DATA_WIDTH-1:0] tw_data,
    output logic                    tw_valid,
    input  logic                    tw_ready
);

    localparam int WW   = 2 * DATA_WIDTH;
    localparam int PW   = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CNTW = $clog2(FIFO_DEPTH + 1);
    localparam int OCCW = $clog2(FIFO_DEPTH + 3);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_FETCH = 2'd1;
    localparam logic [1:0] ST_DRAIN = 2'd2;

    logic [1:0]      state;
    logic [2:0]      stage_q;
    logic [3:0]      j;
    logic [3:0]      out_cnt;
    logic [1:0]      pipe;
    logic [CNTW-1:0] count;
    logic [PW-1:0]   wr_ptr;
    logic [PW-1:0]   rd_ptr;
    logic [WW-1:0]   mem [FIFO_DEPTH];

    logic [OCCW-1:0] occupancy;
    logic            credit_ok;
    logic            issue;
    logic            push;
    logic            pop;
    logic [3:0]      strided_addr;
    logic [WW-1:0]   head;

    // Requests in the ROM pipe already own a FIFO slot, so they count against the credit.
    assign occupancy    = OCCW'(count) + OCCW'(pipe[0]) + OCCW'(pipe[1]);
    assign credit_ok    = occupancy < OCCW'(FIFO_DEPTH);
    assign issue        = (state == ST_FETCH) && credit_ok;
    assign strided_addr = (j & (4'hF >> stage_q)) << stage_q;

    assign rom_en   = issue;
    assign rom_addr = issue ? strided_addr : 4'd0;
    assign busy     = (state != ST_IDLE);

    assign push     = pipe[1];
    assign tw_valid = (count != '0);
    assign pop      = tw_valid && tw_ready;
    assign done     = (state == ST_DRAIN) && pop && (out_cnt == 4'd15);

    // NOTE: sequential state uses non-blocking assignments so every flop samples
    // pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= ST_IDLE;
            stage_q <= 3'd0;
            j       <= 4'd0;
            out_cnt <= 4'd0;
            pipe    <= 2'b00;
        end else begin
            pipe <= {pipe[0], issue};
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        state   <= ST_FETCH;
                        stage_q <= (stage > 3'd4) ? 3'd4 : stage;
                        j       <= 4'd0;
                        out_cnt <= 4'd0;
                    end
                end
                ST_FETCH: begin
                    if (issue) begin
                        j <= j + 4'd1;
                        if (j == 4'd15) begin
                            state <= ST_DRAIN;
                        end
                    end
                end
                ST_DRAIN: begin
                    if (done) begin
                        state <= ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
            if (pop) begin
                out_cnt <= out_cnt + 4'd1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            count  <= '0;
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push) begin
                wr_ptr <= (wr_ptr == PW'(FIFO_DEPTH - 1)) ? '0 : wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= (rd_ptr == PW'(FIFO_DEPTH - 1)) ? '0 : rd_ptr + 1'b1;
            end
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
            if (push) begin
                assert (count < CNTW'(FIFO_DEPTH))
                    else $error("twiddle_fetch: FIFO written while full");
            end
        end
    end

    // NOTE: storage has no reset; the count gates tw_valid, so stale entries are never seen.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= rom_data;
        end
    end

    assign head = mem[rd_ptr];

`ifdef TW_CONJ_EN
    logic [DATA_WIDTH-1:0] imag_neg;

    // NOTE: every always_comb output gets a default first so no latch is inferred.
    always_comb begin
        imag_neg = -head[DATA_WIDTH-1:0];
        if (head[DATA_WIDTH-1:0] == {1'b1, {(DATA_WIDTH-1){1'b0}}}) begin
            imag_neg = {1'b0, {(DATA_WIDTH-1){1'b1}}};
        end
    end

    assign tw_data = tw_valid ? {head[WW-1:DATA_WIDTH], imag_neg} : '0;
`else
    assign tw_data = tw_valid ? head : '0;
`endif

endmodule

// File: tb/tb_twiddle_fetch.sv
// Self-checking bench for twiddle_fetch: spot-value table plus a cycle-level
// credit/stream reference model driven with fixed, backpressured and random tw_ready.
`timescale 1ns/1ps

module tb_twiddle_fetch;

    localparam int DEPTH = 4;
    localparam int MAXC  = 300;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [2:0]  stage;
    logic        busy;
    logic        done;
    logic        rom_en;
    logic [3:0]  rom_addr;
    logic [31:0] rom_data;
    logic [31:0] tw_data;
    logic        tw_valid;
    logic        tw_ready;

    logic [31:0] rom_mem [16];
    logic [31:0] rom_d1;

    logic        log_en    [MAXC];
    logic [3:0]  log_addr  [MAXC];
    logic        log_valid [MAXC];
    logic [31:0] log_data  [MAXC];
    logic        log_done  [MAXC];

    int n_checks = 0;
    int n_fail   = 0;

    typedef struct {
        int          stage;
        int          off;
        logic        en;
        logic [3:0]  addr;
        logic        valid;
        logic [31:0] data;
        logic        done;
    } vec_t;

    vec_t vecs[$];

    twiddle_fetch #(.DATA_WIDTH(16), .FIFO_DEPTH(DEPTH)) dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .stage    (stage),
        .busy     (busy),
        .done     (done),
        .rom_en   (rom_en),
        .rom_addr (rom_addr),
        .rom_data (rom_data),
        .tw_data  (tw_data),
        .tw_valid (tw_valid),
        .tw_ready (tw_ready)
    );

    always #5 clk = ~clk;

    // Two-cycle-latency ROM; a junk word outside read cycles exposes mistimed capture.
    always @(posedge clk) begin
        rom_d1   <= rom_en ? rom_mem[rom_addr] : 32'hDEAD_BEEF;
        rom_data <= rom_d1;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] cj(input logic [31:0] w);
`ifdef TW_CONJ_EN
        int im;
        im = -int'($signed(w[15:0]));
        if (im > 32767) im = 32767;
        return {w[31:16], 16'(im)};
`else
        return w;
`endif
    endfunction

    function automatic logic [3:0] addr_of(input int s, input int idx);
        return 4'(((idx % (16 >> s)) << s) % 16);
    endfunction

    // Cycle-level model: outstanding = issued - accepted bounds issue; a word is
    // poppable three cycles after its request. Offset 0 is the start cycle.
    task automatic run_stage(input int s, input int mode, input int xoff, input logic [2:0] xstage);
        int issued, popped, done_c, sc, avail;
        int issue_cyc [16];
        logic rdy, e_busy, e_en, e_valid, e_done;
        logic [3:0]  e_addr;
        logic [31:0] e_data;
        sc = (s > 4) ? 4 : s;
        issued = 0;
        popped = 0;
        done_c = -1;
        for (int c = 0; c < MAXC; c++) begin
            @(negedge clk);
            start = (c == 0) || (c == xoff);
            stage = (c == 0) ? 3'(s) : xstage;
            case (mode)
                0:       rdy = 1'b1;
                1:       rdy = (c < 12) ? 1'b0 : 1'((c % 2));
                default: rdy = 1'($urandom_range(0, 1));
            endcase
            tw_ready = rdy;
            #1;
            e_busy = (c >= 1) && (done_c < 0);
            e_en   = e_busy && (issued < 16) && ((issued - popped) < DEPTH);
            e_addr = addr_of(sc, issued);
            avail  = -popped;
            for (int k = 0; k < issued; k++) begin
                if (issue_cyc[k] <= c - 3) avail++;
            end
            e_valid = (avail > 0);
            e_data  = cj(rom_mem[addr_of(sc, popped)]);
            e_done  = e_valid && rdy && (popped == 15);

            log_en[c]    = rom_en;
            log_addr[c]  = rom_addr;
            log_valid[c] = tw_valid;
            log_data[c]  = tw_data;
            log_done[c]  = done;

            check($sformatf("s%0d busy c=%0d", s, c), {31'b0, busy}, {31'b0, e_busy});
            check($sformatf("s%0d rom_en c=%0d", s, c), {31'b0, rom_en}, {31'b0, e_en});
            if (e_en) check($sformatf("s%0d rom_addr c=%0d", s, c), {28'b0, rom_addr}, {28'b0, e_addr});
            check($sformatf("s%0d tw_valid c=%0d", s, c), {31'b0, tw_valid}, {31'b0, e_valid});
            if (e_valid) check($sformatf("s%0d tw_data c=%0d", s, c), tw_data, e_data);
            check($sformatf("s%0d done c=%0d", s, c), {31'b0, done}, {31'b0, e_done});

            if (e_en) begin
                issue_cyc[issued] = c;
                issued++;
            end
            if (e_valid && rdy) popped++;
            if (e_done) done_c = c;
            if (done_c >= 0 && c >= done_c + 2) break;
        end
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic apply_table(input int s);
        foreach (vecs[i]) begin
            if (vecs[i].stage == s) begin
                check($sformatf("tbl s%0d en@%0d", s, vecs[i].off), {31'b0, log_en[vecs[i].off]}, {31'b0, vecs[i].en});
                if (vecs[i].en)
                    check($sformatf("tbl s%0d addr@%0d", s, vecs[i].off), {28'b0, log_addr[vecs[i].off]}, {28'b0, vecs[i].addr});
                check($sformatf("tbl s%0d valid@%0d", s, vecs[i].off), {31'b0, log_valid[vecs[i].off]}, {31'b0, vecs[i].valid});
                if (vecs[i].valid)
                    check($sformatf("tbl s%0d data@%0d", s, vecs[i].off), log_data[vecs[i].off], vecs[i].data);
                check($sformatf("tbl s%0d done@%0d", s, vecs[i].off), {31'b0, log_done[vecs[i].off]}, {31'b0, vecs[i].done});
            end
        end
    endtask

    initial begin
        int npulse;
        int s_r, x_r;

        rom_mem = '{32'h0001_0000, 32'h7D8A_E707, 32'h7642_CF04, 32'h6A6E_B8E3,
                    32'h5A83_A57D, 32'h471D_9592, 32'h30FC_89BE, 32'h18F9_8276,
                    32'h0000_0001, 32'hE707_8276, 32'hCF04_89BE, 32'hB8E3_9592,
                    32'hA57D_A57D, 32'h9592_B8E3, 32'h89BE_CF04, 32'h8276_E707};

        // {stage, offset, rom_en, rom_addr, tw_valid, tw_data, done}
        vecs.push_back('{0,  0, 1'b0, 4'd0,  1'b0, 32'h0, 1'b0});
        vecs.push_back('{0,  1, 1'b1, 4'd0,  1'b0, 32'h0, 1'b0});
        vecs.push_back('{0,  2, 1'b1, 4'd1,  1'b0, 32'h0, 1'b0});
        vecs.push_back('{0,  3, 1'b1, 4'd2,  1'b0, 32'h0, 1'b0});
        vecs.push_back('{0,  4, 1'b1, 4'd3,  1'b1, cj(32'h0001_0000), 1'b0});
        vecs.push_back('{0,  5, 1'b1, 4'd4,  1'b1, cj(32'h7D8A_E707), 1'b0});
        vecs.push_back('{0, 16, 1'b1, 4'd15, 1'b1, cj(32'hA57D_A57D), 1'b0});
        vecs.push_back('{0, 17, 1'b0, 4'd0,  1'b1, cj(32'h9592_B8E3), 1'b0});
        vecs.push_back('{0, 19, 1'b0, 4'd0,  1'b1, cj(32'h8276_E707), 1'b1});
        vecs.push_back('{0, 20, 1'b0, 4'd0,  1'b0, 32'h0, 1'b0});
        vecs.push_back('{2,  1, 1'b1, 4'd0,  1'b0, 32'h0, 1'b0});
        vecs.push_back('{2,  2, 1'b1, 4'd4,  1'b0, 32'h0, 1'b0});
        vecs.push_back('{2,  3, 1'b1, 4'd8,  1'b0, 32'h0, 1'b0});
        vecs.push_back('{2,  4, 1'b1, 4'd12, 1'b1, cj(32'h0001_0000), 1'b0});
        vecs.push_back('{2,  5, 1'b1, 4'd0,  1'b1, cj(32'h5A83_A57D), 1'b0});
        vecs.push_back('{2,  6, 1'b1, 4'd4,  1'b1, cj(32'h0000_0001), 1'b0});
        vecs.push_back('{2,  7, 1'b1, 4'd8,  1'b1, cj(32'hA57D_A57D), 1'b0});
        vecs.push_back('{2, 16, 1'b1, 4'd12, 1'b1, cj(32'h0001_0000), 1'b0});
        vecs.push_back('{2, 19, 1'b0, 4'd0,  1'b1, cj(32'hA57D_A57D), 1'b1});
        vecs.push_back('{6,  1, 1'b1, 4'd0,  1'b0, 32'h0, 1'b0});
        vecs.push_back('{6, 10, 1'b1, 4'd0,  1'b1, cj(32'h0001_0000), 1'b0});
        vecs.push_back('{6, 16, 1'b1, 4'd0,  1'b1, cj(32'h0001_0000), 1'b0});
        vecs.push_back('{6, 19, 1'b0, 4'd0,  1'b1, cj(32'h0001_0000), 1'b1});

        rst = 1'b1;
        start = 1'b0;
        stage = 3'd0;
        tw_ready = 1'b0;
        repeat (3) @(negedge clk);
        #1;
        check("reset busy", {31'b0, busy}, 32'd0);
        check("reset done", {31'b0, done}, 32'd0);
        check("reset rom_en", {31'b0, rom_en}, 32'd0);
        check("reset rom_addr", {28'b0, rom_addr}, 32'd0);
        check("reset tw_valid", {31'b0, tw_valid}, 32'd0);
        check("reset tw_data", tw_data, 32'd0);
        @(negedge clk);
        rst = 1'b0;

        // Fixed stages with tw_ready high, plus the spot-value table.
        run_stage(0, 0, -1, 3'd0);
        apply_table(0);
        run_stage(2, 0, -1, 3'd0);
        apply_table(2);
        run_stage(6, 0, -1, 3'd0);
        apply_table(6);

        // Backpressure: ready low for 12 cycles, then toggling.
        run_stage(0, 1, -1, 3'd0);
        npulse = 0;
        for (int c = 1; c < 12; c++) npulse += int'(log_en[c]);
        check("bp rom_en pulses", 32'(npulse), 32'd4);
        check("bp held valid", {31'b0, log_valid[11]}, 32'd1);
        check("bp held data", log_data[11], cj(32'h0001_0000));

        // start coinciding with done is ignored.
        run_stage(3, 0, 19, 3'd1);
        check("start@done ignored busy", {31'b0, busy}, 32'd0);

        // Reset mid-sequence, restart at T+10, extra start at T+12 ignored.
        @(negedge clk);
        start = 1'b1;
        stage = 3'd0;
        tw_ready = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (4) @(negedge clk);
        #1;
        check("pre-rst valid T+5", {31'b0, tw_valid}, 32'd1);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        #1;
        check("post-rst busy", {31'b0, busy}, 32'd0);
        check("post-rst rom_en", {31'b0, rom_en}, 32'd0);
        check("post-rst tw_valid", {31'b0, tw_valid}, 32'd0);
        check("post-rst tw_data", tw_data, 32'd0);
        for (int c = 8; c < 10; c++) begin
            @(negedge clk);
            #1;
            check($sformatf("post-rst stale T+%0d", c), {31'b0, tw_valid}, 32'd0);
        end
        run_stage(0, 0, 2, 3'd4);

`ifdef TW_CONJ_EN
        run_stage(0, 0, -1, 3'd0);
        check("conj W1", log_data[5], 32'h7D8A_18F9);
        check("conj W4", log_data[8], 32'h5A83_5A83);
        rom_mem[0] = 32'h0000_8000;
        run_stage(4, 0, -1, 3'd0);
        check("conj saturate", log_data[4], 32'h0000_7FFF);
        rom_mem[0] = 32'h0001_0000;
`endif

        // Random stages, random tw_ready, stray start pulses mid-sequence.
        for (int r = 0; r < 8; r++) begin
            s_r = $urandom_range(0, 7);
            x_r = $urandom_range(1, 15);
            run_stage(s_r, 2, x_r, 3'($urandom_range(0, 7)));
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/twiddle_fetch.md
# twiddle_fetch

Twiddle-factor fetch sequencer for one radix-2 FFT stage. On `start` it generates the ordered twiddle address sequence for the selected stage and drives the twiddle ROM's `en`/`addr` port. It compensates for the ROM's fixed 2-cycle read latency and buffers the returned words in a 4-entry FIFO. Words are presented to the butterfly PE as a valid/ready stream with full backpressure.

## Interface
Parameters:
- `DATA_WIDTH`, default `` `DATA_WIDTH `` (16) from `parameters.vh`: width of each real/imag half.
- `FIFO_DEPTH`, default 4: output buffer depth; also the credit limit.

Ports:
- `clk`  in  1  single clock; all logic on rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `start`  in  1  one-cycle request to fetch one stage's twiddles.
- `stage`  in  3  FFT stage index, sampled with `start`.
- `busy`  out  1  sequence in progress.
- `done`  out  1  one-cycle pulse on acceptance of the 16th twiddle.
- `rom_en`  out  1  ROM read enable.
- `rom_addr`  out  4  ROM address (twiddle index 0..15).
- `rom_data`  in  2*DATA_WIDTH  ROM output; valid exactly 2 cycles after the `rom_en` cycle. `{real, imag}`, Q1.15.
- `tw_data`  out  2*DATA_WIDTH  twiddle to PE, `{real, imag}`.
- `tw_valid`  out  1  `tw_data` valid.
- `tw_ready`  in  1  PE accepts `tw_data`.

## Operation
- States: IDLE, FETCH, DRAIN.
  - IDLE to FETCH on `start`. `stage` is latched; values 5..7 clamp to 4. The butterfly counter j is cleared.
  - FETCH issues j = 0..15.
  - After j = 15 is issued, go to DRAIN.
  - DRAIN to IDLE in the cycle the 16th word handshakes. `done` is asserted in that same cycle.
- Address for butterfly j: `rom_addr = (j & ((16>>s)-1)) << s`, 4-bit result.
  - s=0: 0,1,…,15.
  - s=2: 0,4,8,12, repeated 4 times.
  - s=4: all 0.
- Credit rule:
  - A request may issue in a cycle only when inflight + fifo_count < FIFO_DEPTH.
  - inflight = number of requests issued in the previous 2 cycles, held in a 2-bit valid shift pipe.
  - Issuing a request means `rom_en`=1 with the address for the current j; j then increments.
  - `rom_en`=0 in every other cycle.
- Capture: when the pipe's stage-2 bit is set, `rom_data` is written to the FIFO. The credit rule guarantees the FIFO is never full at a write, so overflow cannot occur.
- FIFO: first-word-fall-through, in-order.
  - `tw_valid` = FIFO non-empty.
  - A pop happens on `tw_valid & tw_ready`.
  - A simultaneous push and pop keeps the count unchanged.
- `start` while `busy` is ignored; the latched stage is unchanged.
- `tw_ready` may toggle arbitrarily. `tw_data` is stable while `tw_valid & !tw_ready`.

## Timing
- Reset values: `busy`=0, `done`=0, `rom_en`=0, `rom_addr`=0, `tw_valid`=0, `tw_data`=0. FIFO is emptied, the pipe is cleared, state is IDLE.
- `rst` mid-operation: the next cycle is as reset. ROM results still in flight are discarded and never written.
- Latency from `start` sampled at cycle T:
  - first `rom_en` at T+1;
  - FIFO write at T+3;
  - first `tw_valid` at T+4.
- `busy`: high from T+1 through the `done` cycle inclusive.
- With `tw_ready` held high: 1 twiddle/cycle, `tw_valid` high T+4..T+19, `done` at T+19.
- With `tw_ready` held low: exactly 4 requests issue (T+1..T+4); then `rom_en` stays 0 until a pop frees a credit.
- After a pop at cycle P, the next request issues at P+1 at the earliest.
- `start` is accepted in the same cycle `done` pulses only if the state is IDLE, i.e. not accepted in that cycle.

## Configuration
- `TW_CONJ_EN` defined: inverse-FFT mode.
  - `tw_data` imag = −imag, saturating; 0x8000 maps to 0x7FFF.
  - Real half unchanged.
  - Negation sits at the FIFO read side and adds no latency.
- `TW_CONJ_EN` undefined: `tw_data` = `rom_data` word unmodified.

## Test plan
- Stage 0, `tw_ready`=1, `start` at T:
  - `rom_addr` 0..15 on T+1..T+16;
  - `tw_data` T+4 = 0x0001_0000, T+5 = 0x7D8A_E707, T+19 = 0x8276_E707;
  - `done` at T+19.
- Stage 2: address sequence 0,4,8,12 ×4; 16 outputs cycling 0x0001_0000, 0x5A83_A57D, 0x0000_0001, 0xA57D_A57D.
- Stage 6 (clamped to 4): 16 words all 0x0001_0000, all from `rom_addr`=0.
- Backpressure, stage 0, `tw_ready`=0 from T:
  - exactly 4 `rom_en` pulses; `tw_valid` stays high with 0x0001_0000.
  - Then toggle `tw_ready` 1/0 per cycle: all 16 words arrive in order, with no loss or duplicate.
- `rst` at T+6, then `start` at T+10: no stale word appears; the new sequence starts fresh at T+14. A second `start` at T+12 is ignored.
- `TW_CONJ_EN` build, stage 0: W1 → 0x7D8A_18F9, W4 → 0x5A83_5A83. An injected ROM word 0x0000_8000 → 0x0000_7FFF.
